// File: rtl/register_file_pkg.sv
// Shared widths and scoreboard types for the operand-fetch register file.
// RA_IDX is the call link register the OF stage claims for call instructions.
package register_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int RA_IDX   = 15;
  localparam int CNT_W    = 2;

  typedef logic [CNT_W-1:0] pend_cnt_t;

  localparam pend_cnt_t CNT_MAX  = '1;
  localparam pend_cnt_t CNT_ZERO = '0;
  localparam pend_cnt_t CNT_ONE  = pend_cnt_t'(1);

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register saturating pending-write counters with a sticky over/underflow flag.
// Latency: counters update on the clk edge; the read-side counter taps are combinational.
// Backpressure: none here; the caller gates claims with stall before they reach this block.
module reg_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output pend_cnt_t         cnt_a,
  output pend_cnt_t         cnt_b,
  output logic              sb_ovf
);

  localparam int NUM = 1 << ADDR_W;

  pend_cnt_t      cnt     [NUM];
  pend_cnt_t      cnt_nxt [NUM];
  logic [NUM-1:0] claim_hit;
  logic [NUM-1:0] wb_hit;
  logic           err;

  always_comb begin
    claim_hit             = '0;
    wb_hit                = '0;
    claim_hit[claim_addr] = claim_en;
    wb_hit[wb_addr]       = wb_en;
  end

  // A claim and a write-back to the same index cancel out and leave the count alone.
  always_comb begin
    err = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      cnt_nxt[i] = cnt[i];
      if (claim_hit[i] && !wb_hit[i]) begin
        if (cnt[i] == CNT_MAX) err = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (wb_hit[i] && !claim_hit[i]) begin
        if (cnt[i] == CNT_ZERO) err = 1'b1;
        else                    cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) cnt[i] <= CNT_ZERO;
      sb_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < NUM; i++) cnt[i] <= cnt_nxt[i];
      if (err) sb_ovf <= 1'b1;
    end
  end

  assign cnt_a = cnt[rd_addr_a];
  assign cnt_b = cnt[rd_addr_b];

endmodule

// File: rtl/register_file.sv
// Two-read/one-write flop register file with write-through bypass and a hazard scoreboard.
// Latency: reads are combinational; writes and claims commit on the rising clk edge.
// Backpressure: stall holds OF while a consumed operand has an unresolved pending write.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              use_a,
  input  logic              use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              busy_a,
  output logic              busy_b,
  output logic              stall,
  output logic              sb_ovf
);

  localparam int NUM = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NUM];
  pend_cnt_t         cnt_a;
  pend_cnt_t         cnt_b;
  logic              byp_a;
  logic              byp_b;
  logic              claim_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign byp_a = !reset && wb_en && (wb_addr == rd_addr_a);
  assign byp_b = !reset && wb_en && (wb_addr == rd_addr_b);

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (byp_a)       rd_data_a = wb_data;
    else if (!reset) rd_data_a = regs[rd_addr_a];
    if (byp_b)       rd_data_b = wb_data;
    else if (!reset) rd_data_b = regs[rd_addr_b];
  end

  // The last outstanding write arriving this cycle is forwarded, so it no longer blocks.
  assign busy_a = !reset && (cnt_a != CNT_ZERO) && !(byp_a && cnt_a == CNT_ONE);
  assign busy_b = !reset && (cnt_b != CNT_ZERO) && !(byp_b && cnt_b == CNT_ONE);

  assign stall    = (busy_a & use_a) | (busy_b & use_b);
  assign claim_ok = claim_en & ~stall;

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_ok),
    .claim_addr (claim_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .sb_ovf     (sb_ovf)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, bypass, scoreboard hazards, saturation and mid-run reset.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rd_addr_a = '0;
  logic [3:0]  rd_addr_b = '0;
  logic        use_a = 1'b0;
  logic        use_b = 1'b0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        claim_en = 1'b0;
  logic [3:0]  claim_addr = '0;
  logic        busy_a;
  logic        busy_b;
  logic        stall;
  logic        sb_ovf;

  int total = 0;
  int bad   = 0;

  register_file #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .use_a      (use_a),
    .use_b      (use_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .stall      (stall),
    .sb_ovf     (sb_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en    = 1'b0;
    claim_en = 1'b0;
  endtask

  initial begin
    // Reset with live write/claim traffic: bypass and hazards must be masked, traffic dropped.
    #1 reset = 1'b1;
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hAAAA_AAAA;
    claim_en = 1'b1; claim_addr = 4'd0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0; use_a = 1'b1; use_b = 1'b1;
    #1;
    chk("rst_rd_a_no_bypass", rd_data_a, 32'h0);
    chk("rst_rd_b_no_bypass", rd_data_b, 32'h0);
    chk("rst_busy_stall", {29'h0, busy_a, busy_b, stall}, 32'h0);
    chk("rst_sb_ovf", {31'h0, sb_ovf}, 32'h0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_write_dropped", rd_data_a, 32'h0);
    chk("rst_claim_dropped", {31'h0, busy_a}, 32'h0);

    // Every register reads zero with no hazard.
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
      #1;
      chk($sformatf("init_rd_a_r%0d", i), rd_data_a, 32'h0);
      chk($sformatf("init_hz_r%0d", i), {29'h0, busy_a, busy_b, stall}, 32'h0);
    end
    use_a = 1'b0; use_b = 1'b0;

    // Write-through bypass on port A, port B on another index unaffected.
    tick();
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD_BEEF;
    rd_addr_a = 4'd3; rd_addr_b = 4'd4;
    #1;
    chk("byp_same_cycle", rd_data_a, 32'hDEAD_BEEF);
    chk("byp_other_port", rd_data_b, 32'h0);
    tick();
    idle();
    #1;
    chk("wr_next_cycle", rd_data_a, 32'hDEAD_BEEF);
    chk("underflow_sets_ovf", {31'h0, sb_ovf}, 32'h1);
    tick();
    chk("wr_held", rd_data_a, 32'hDEAD_BEEF);

    // Asynchronous reset between edges clears storage and the sticky flag.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("async_clear_r3", rd_data_a, 32'h0);
    chk("async_clear_ovf", {31'h0, sb_ovf}, 32'h0);

    // Claim r5, then hazard resolved by the bypass in the write-back cycle.
    tick();
    claim_en = 1'b1; claim_addr = 4'd5;
    tick();
    idle();
    rd_addr_b = 4'd5; use_b = 1'b1;
    #1;
    chk("r5_busy_stall", {30'h0, busy_b, stall}, 32'h3);
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h12;
    #1;
    chk("r5_wb_resolves", {30'h0, busy_b, stall}, 32'h0);
    chk("r5_wb_bypass", rd_data_b, 32'h12);
    tick();
    idle();
    #1;
    chk("r5_after_wb", {30'h0, busy_b, stall}, 32'h0);
    chk("r5_stored", rd_data_b, 32'h12);
    chk("r5_no_ovf", {31'h0, sb_ovf}, 32'h0);

    // A claim presented while stalled is ignored.
    claim_en = 1'b1; claim_addr = 4'd5; use_b = 1'b0;
    tick();
    use_b = 1'b1;
    claim_addr = 4'd9;
    #1;
    chk("stall_active", {31'h0, stall}, 32'h1);
    tick();
    idle();
    use_b = 1'b0; rd_addr_a = 4'd9; use_a = 1'b1;
    #1;
    chk("stalled_claim_dropped", {30'h0, busy_a, stall}, 32'h0);
    use_a = 1'b0;
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h13;
    tick();
    idle();
    #1;
    chk("r5_cleared", {31'h0, busy_b}, 32'h0);

    // Saturate r7 at 3, then drain with three write-backs.
    rd_addr_a = 4'd7;
    claim_en = 1'b1; claim_addr = 4'd7;
    tick(); tick(); tick();
    chk("r7_busy_at3", {31'h0, busy_a}, 32'h1);
    chk("r7_no_ovf_yet", {31'h0, sb_ovf}, 32'h0);
    tick();
    idle();
    #1;
    chk("r7_sat_ovf", {31'h0, sb_ovf}, 32'h1);
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h1;
    #1;
    chk("r7_wb1_busy", {31'h0, busy_a}, 32'h1);
    tick();
    wb_data = 32'h2;
    tick();
    idle();
    #1;
    chk("r7_cnt1_busy", {31'h0, busy_a}, 32'h1);
    wb_en = 1'b1; wb_data = 32'h3;
    #1;
    chk("r7_last_wb_unbusy", {31'h0, busy_a}, 32'h0);
    tick();
    idle();
    #1;
    chk("r7_drained", {31'h0, busy_a}, 32'h0);
    chk("r7_data", rd_data_a, 32'h3);
    chk("ovf_sticky", {31'h0, sb_ovf}, 32'h1);

    // Simultaneous claim and write-back on r2 leaves the count at 1.
    rd_addr_a = 4'd2;
    claim_en = 1'b1; claim_addr = 4'd2;
    tick();
    wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h55;
    #1;
    chk("r2_both_cycle_unbusy", {31'h0, busy_a}, 32'h0);
    tick();
    idle();
    #1;
    chk("r2_still_busy", {31'h0, busy_a}, 32'h1);
    chk("r2_data", rd_data_a, 32'h55);

    // Claim r11 and write back r10 in the same edge.
    claim_en = 1'b1; claim_addr = 4'd10;
    tick();
    wb_en = 1'b1; wb_addr = 4'd10; wb_data = 32'hA0;
    claim_addr = 4'd11;
    tick();
    idle();
    rd_addr_a = 4'd10; rd_addr_b = 4'd11;
    #1;
    chk("indep_r10_clear", {31'h0, busy_a}, 32'h0);
    chk("indep_r11_busy", {31'h0, busy_b}, 32'h1);
    chk("indep_r10_data", rd_data_a, 32'hA0);

    // Mid-run reset with r4 pending, then a fresh claim of r4.
    claim_en = 1'b1; claim_addr = 4'd4;
    tick();
    idle();
    rd_addr_a = 4'd4; rd_addr_b = 4'd7;
    #1;
    chk("r4_pending", {31'h0, busy_a}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {30'h0, busy_a, busy_b}, 32'h0);
    chk("midrst_ovf", {31'h0, sb_ovf}, 32'h0);
    reset = 1'b0;
    #1;
    chk("midrst_cnt_cleared", {31'h0, busy_a}, 32'h0);
    chk("midrst_r7_cleared", rd_data_b, 32'h0);
    claim_en = 1'b1; claim_addr = 4'd4;
    tick();
    idle();
    #1;
    chk("r4_reclaimed", {31'h0, busy_a}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32: register and data width.
REQ-002 Parameter ADDR_W, default 4: register index width; 16 registers, index 15 = ra.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rd_addr_a  input  ADDR_W  read port A index; driven by the OF stage rs1/ra select.
REQ-006 rd_addr_b  input  ADDR_W  read port B index; driven by the OF stage rs2/rd select.
REQ-007 use_a  input  1  current OF instruction actually consumes port A.
REQ-008 use_b  input  1  current OF instruction actually consumes port B.
REQ-009 rd_data_a  output  DATA_W  port A data; feeds OF op1.
REQ-010 rd_data_b  output  DATA_W  port B data; feeds OF op2.
REQ-011 wb_en  input  1  write-back strobe from the WB stage.
REQ-012 wb_addr  input  ADDR_W  write-back destination index.
REQ-013 wb_data  input  DATA_W  write-back value.
REQ-014 claim_en  input  1  OF instruction leaving OF this cycle will write a register.
REQ-015 claim_addr  input  ADDR_W  destination being claimed (rd, or 15 for call).
REQ-016 busy_a  output  1  port A register has an unresolved pending write.
REQ-017 busy_b  output  1  port B register has an unresolved pending write.
REQ-018 stall  output  1  = (busy_a & use_a) | (busy_b & use_b); OF holds when high.
REQ-019 sb_ovf  output  1  sticky scoreboard overflow/underflow error flag.

Function
REQ-020 Reads SHALL be combinational; no read latency.
REQ-021 Writes SHALL take effect at the rising clk edge when wb_en=1.
REQ-022 If wb_en=1 and wb_addr equals a read address, that port SHALL return wb_data in the same cycle (write-through bypass).
REQ-023 Each register SHALL have a 2-bit pending counter.
REQ-024 Counter update per edge: claim only -> +1; wb only -> -1; claim and wb to the same index -> unchanged.
REQ-025 Claim and wb to different indices SHALL update both counters independently in the same edge.
REQ-026 A counter at 3 receiving a claim-only SHALL hold at 3 and set sb_ovf.
REQ-027 A counter at 0 receiving a wb-only SHALL hold at 0 and set sb_ovf.
REQ-028 sb_ovf SHALL clear only on reset.
REQ-029 busy_x SHALL be 1 iff the counter for rd_addr_x is nonzero.
REQ-030 Exception to REQ-029: busy_x SHALL be 0 when wb_en=1, wb_addr=rd_addr_x and that counter equals 1, since the bypass resolves the hazard.
REQ-031 stall SHALL be purely combinational from current state and inputs.
REQ-032 claim_en SHALL be ignored in any cycle where stall=1.

Reset
REQ-033 On reset assertion, all registers SHALL become 0 immediately (asynchronously).
REQ-034 On reset assertion, all pending counters SHALL become 0 and sb_ovf SHALL become 0.
REQ-035 While reset=1: rd_data_a/b=0 (subject only to the REQ-022 bypass, which is disabled under reset), busy_a/b=0, stall=0.
REQ-036 A write or claim coincident with the edge at which reset deasserts SHALL be dropped.

Structure
REQ-037 Shared package SHALL hold DATA_W, ADDR_W, NUM_REGS=16 and RA_IDX=15.
REQ-038 The per-register counter array with its overflow logic SHALL be one sub-module, reg_scoreboard.
REQ-039 Storage SHALL be plain flops; no memory macro.

Verification
REQ-040 Reset, then read r0..r15 -> every value 0, busy=0, stall=0.
REQ-041 wb_en=1, wb_addr=3, wb_data=0xDEADBEEF, rd_addr_a=3 in the same cycle -> rd_data_a=0xDEADBEEF that cycle and on the following cycles.
REQ-042 claim r5; next cycle rd_addr_b=5, use_b=1 -> busy_b=1, stall=1. Assert wb to r5 with data 0x12 -> busy_b=0, stall=0, rd_data_b=0x12 in that same cycle.
REQ-043 Claim r7 three times, then claim r7 again -> counter holds at 3 and sb_ovf=1. Apply 3 write-backs -> busy on r7 clears. sb_ovf stays 1 until reset.
REQ-044 Simultaneous claim r2 and wb r2 with counter=1 -> counter remains 1 and busy stays 1 on the next cycle.
REQ-045 Assert reset mid-sequence with pending r4 -> registers and counters read 0 at once; the next claim of r4 reads busy=1 after one edge.
